// File: rtl/sdram_multibank_scheduler.sv
// sdram_multibank_scheduler: time-sliced multi-bank SDRAM command scheduler with CAS capture and auto-refresh
module sdram_multibank_scheduler #(
   parameter int NUM_BANKS        = 2,
   parameter int ADDR_DEPTH       = 23,
   parameter int COL_DEPTH        = 10,
   parameter int CAS_LATENCY      = 2,
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic [NUM_BANKS-1:0]            req,
   input  logic [NUM_BANKS-1:0]            we,
   input  logic [NUM_BANKS*ADDR_DEPTH-1:0] addr,
   input  logic [NUM_BANKS*8-1:0]          wdata,
   output logic [NUM_BANKS-1:0]            ack,
   output logic [NUM_BANKS*8-1:0]          rdata,
   output logic [NUM_BANKS-1:0]            rvalid,
   output logic                            refresh_active,
   input  logic [15:0]                     sd_data_in,
   output logic [15:0]                     sd_data_out,
   output logic                            sd_data_out_en,
   output logic [12:0]                     sd_a,
   output logic [1:0]                      sd_ba,
   output logic [2:0]                      sd_cmd,
   output logic [1:0]                      sd_dqm
);
   localparam int F         = 4 * NUM_BANKS;
   localparam int FW        = $clog2(F);
   localparam int BW        = $clog2(NUM_BANKS);
   localparam int RW        = $clog2(REFRESH_INTERVAL);
   localparam int ROW_DEPTH = ADDR_DEPTH - COL_DEPTH - 1;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_NOP = 3'b111;

   logic [FW-1:0]                          fc_q, fc_d;
   logic [RW-1:0]                          rc_q, rc_d;
   logic                                   refresh_q, refresh_d;
   logic [NUM_BANKS-1:0]                   busy_q, busy_d, we_q, we_d, rvalid_q, rvalid_d;
   logic [NUM_BANKS-1:0][ADDR_DEPTH-1:0]   addr_q, addr_d;
   logic [NUM_BANKS-1:0][7:0]              wdata_q, wdata_d, rdata_q, rdata_d;
   logic [NUM_BANKS-1:0]                   accept, cap;
   logic                                   frame_end, refresh_next, ul;
   logic [BW-1:0]                          slot;
   logic [FW-BW-1:0]                       phase;
   logic [ADDR_DEPTH-1:0]                  slot_addr;
   logic [ROW_DEPTH-1:0]                   row;
   logic [COL_DEPTH-1:0]                   col;

   assign frame_end      = fc_q == FW'(F - 1);
   assign refresh_next   = rc_q == RW'(REFRESH_INTERVAL - 1);
   assign accept         = (frame_end && !refresh_next) ? (req & {NUM_BANKS{en}}) : '0;
   assign slot           = fc_q[BW-1:0];
   assign phase          = fc_q[FW-1:BW];
   assign slot_addr      = addr_q[slot];
   assign {row, col, ul} = slot_addr;
   assign ack            = accept;
   assign rdata          = rdata_q;
   assign rvalid         = rvalid_q;
   assign refresh_active = refresh_q;

   // frame/refresh counters, request latching at frame end and read capture
   always_comb begin
      fc_d      = frame_end ? '0 : fc_q + FW'(1);
      rc_d      = frame_end ? (refresh_next ? '0 : rc_q + RW'(1)) : rc_q;
      refresh_d = frame_end ? refresh_next : refresh_q;
      busy_d    = frame_end ? accept : busy_q;
      for (int b = 0; b < NUM_BANKS; b++) begin
         we_d[b]     = accept[b] ? we[b] : we_q[b];
         addr_d[b]   = accept[b] ? addr[b*ADDR_DEPTH +: ADDR_DEPTH] : addr_q[b];
         wdata_d[b]  = accept[b] ? wdata[b*8 +: 8] : wdata_q[b];
         cap[b]      = busy_q[b] && !we_q[b] && fc_q == FW'(NUM_BANKS + b + CAS_LATENCY);
         rvalid_d[b] = cap[b];
         rdata_d[b]  = cap[b] ? (addr_q[b][0] ? sd_data_in[15:8] : sd_data_in[7:0]) : rdata_q[b];
      end
   end

   // SDRAM command for the current slot: refresh, activate, or read/write with auto-precharge
   always_comb begin
      sd_cmd         = CMD_NOP;
      sd_a           = '0;
      sd_ba          = '0;
      sd_dqm         = 2'b11;
      sd_data_out_en = 1'b0;
      sd_data_out    = '0;
      if (refresh_q && fc_q == '0)
         sd_cmd = CMD_REF;
      else if (busy_q[slot] && phase == 2'd0) begin
         sd_cmd = CMD_ACT;
         sd_a   = 13'(row);
         sd_ba  = 2'(slot);
      end else if (busy_q[slot] && phase == 2'd1) begin
         sd_cmd         = we_q[slot] ? CMD_WR : CMD_RD;
         sd_a           = 13'(col) | 13'h400;
         sd_ba          = 2'(slot);
         sd_dqm         = {~ul, ul};
         sd_data_out_en = we_q[slot];
         sd_data_out    = we_q[slot] ? (ul ? {wdata_q[slot], 8'h00} : {8'h00, wdata_q[slot]}) : 16'h0;
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fc_q      <= '0;
         rc_q      <= '0;
         refresh_q <= 1'b0;
         busy_q    <= '0;
         we_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         rvalid_q  <= '0;
      end else begin
         fc_q      <= fc_d;
         rc_q      <= rc_d;
         refresh_q <= refresh_d;
         busy_q    <= busy_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end
endmodule

// File: tb/tb_sdram_multibank_scheduler.sv
// tb_sdram_multibank_scheduler: randomized and directed checks against an absolute-time schedule model
module tb_sdram_multibank_scheduler;
   localparam int NB  = 4;
   localparam int AD  = 23;
   localparam int COL = 10;
   localparam int CL  = 3;
   localparam int RI  = 4;
   localparam int F   = 4 * NB;

   typedef struct packed {
      logic [2:0]  cmd;
      logic [12:0] a;
      logic [1:0]  ba;
      logic [1:0]  dqm;
      logic        oe;
      logic [15:0] dout;
   } bus_t;

   logic              clk = 1'b0;
   logic              rst, en;
   logic [NB-1:0]     req, we, ack, rvalid;
   logic [NB*AD-1:0]  addr;
   logic [NB*8-1:0]   wdata, rdata;
   logic              refresh_active, sd_data_out_en;
   logic [15:0]       sd_data_in, sd_data_out;
   logic [12:0]       sd_a;
   logic [1:0]        sd_ba, sd_dqm;
   logic [2:0]        sd_cmd;

   int                t, errors, checks;
   bus_t              sched[int];
   int                cap_at[int];
   int                rv_at[int];
   logic [NB-1:0][7:0] mrdata;
   logic [NB-1:0]     exp_ack, exp_rv;
   logic              exp_ref;
   bus_t              exp_bus;
   logic [77:0]       exp_v, got_v;

   assign got_v = {ack, rvalid, rdata, refresh_active, sd_cmd, sd_a, sd_ba, sd_dqm, sd_data_out_en, sd_data_out};

   always #5 clk = ~clk;

   sdram_multibank_scheduler #(
      .NUM_BANKS(NB), .ADDR_DEPTH(AD), .COL_DEPTH(COL), .CAS_LATENCY(CL), .REFRESH_INTERVAL(RI)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .rvalid(rvalid), .refresh_active(refresh_active),
      .sd_data_in(sd_data_in), .sd_data_out(sd_data_out), .sd_data_out_en(sd_data_out_en),
      .sd_a(sd_a), .sd_ba(sd_ba), .sd_cmd(sd_cmd), .sd_dqm(sd_dqm)
   );

   task automatic model_reset();
      t = 0;
      sched.delete();
      cap_at.delete();
      rv_at.delete();
      mrdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // expected outputs for cycle t, derived from frame arithmetic and the scheduled-event tables
   task automatic eval();
      int fc, fr;
      #1;
      fc = t % F;
      fr = t / F;
      exp_ack = (fc == F - 1 && (fr + 1) % RI != 0) ? (req & {NB{en}}) : '0;
      exp_ref = fr > 0 && fr % RI == 0;
      exp_rv = '0;
      if (rv_at.exists(t)) exp_rv[rv_at[t]] = 1'b1;
      exp_bus = {3'b111, 13'h0, 2'b00, 2'b11, 1'b0, 16'h0};
      if (exp_ref && fc == 0) exp_bus.cmd = 3'b001;
      if (sched.exists(t)) exp_bus = sched[t];
      exp_v = {exp_ack, exp_rv, mrdata, exp_ref, exp_bus};
   endtask

   // book the next frame's commands for accepted requests, record captures, then clock once
   task automatic adv();
      int base, row, col;
      logic [AD-1:0] a;
      logic [7:0] w;
      logic ul;
      base = (t / F + 1) * F;
      for (int b = 0; b < NB; b++) if (exp_ack[b]) begin
         a = addr[b*AD +: AD];
         w = wdata[b*8 +: 8];
         ul = a[0];
         row = int'(a) / (1 << (COL + 1));
         col = (int'(a) / 2) % (1 << COL);
         sched[base + b] = {3'b011, 13'(row), 2'(b), 2'b11, 1'b0, 16'h0};
         sched[base + NB + b] = {we[b] ? 3'b100 : 3'b101, 13'(col + 1024), 2'(b), ul ? 2'b01 : 2'b10,
                                 we[b], we[b] ? (ul ? {w, 8'h00} : {8'h00, w}) : 16'h0};
         if (!we[b]) cap_at[base + NB + b + CL] = 2 * b + int'(ul);
      end
      if (cap_at.exists(t)) begin
         mrdata[cap_at[t] / 2] = (cap_at[t] % 2 == 1) ? sd_data_in[15:8] : sd_data_in[7:0];
         rv_at[t + 1] = cap_at[t] / 2;
      end
      t++;
      @(negedge clk);
   endtask

   task automatic rand_addr();
      for (int b = 0; b < NB; b++) addr[b*AD +: AD] = AD'($urandom);
   endtask

   task automatic test_reset();
      do_reset();
      repeat (2 * F) begin
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL reset_model t=%0d got=%h exp=%h", t, got_v, exp_v); end
         checks++;
         if ({sd_cmd, sd_dqm, ack, rvalid} !== {3'b111, 2'b11, 4'h0, 4'h0}) begin
            errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", t, {sd_cmd, sd_dqm, ack, rvalid}, {3'b111, 2'b11, 8'h0});
         end
         adv();
      end
   endtask

   task automatic test_write();
      do_reset();
      req = 4'b0001; we = 4'b0001; addr = '0; addr[AD-1:0] = 23'h000C03;
      wdata = '0; wdata[7:0] = 8'hA5; sd_data_in = '0;
      repeat (2 * F) begin
         if (t == F) req = '0;
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL write_model t=%0d got=%h exp=%h", t, got_v, exp_v); end
         if (t == F - 1) begin
            checks++;
            if (ack !== 4'b0001) begin errors++; $display("FAIL write_ack got=%b exp=0001", ack); end
         end
         if (t == F) begin
            checks++;
            if ({sd_cmd, sd_a, sd_ba} !== {3'b011, 13'h0001, 2'd0}) begin
               errors++; $display("FAIL write_act got=%h exp=%h", {sd_cmd, sd_a, sd_ba}, {3'b011, 13'h0001, 2'd0});
            end
         end
         if (t == F + NB) begin
            checks++;
            if ({sd_cmd, sd_a, sd_dqm, sd_data_out, sd_data_out_en} !== {3'b100, 13'h0601, 2'b01, 16'hA500, 1'b1}) begin
               errors++; $display("FAIL write_cmd got=%h exp=%h", {sd_cmd, sd_a, sd_dqm, sd_data_out, sd_data_out_en},
                                  {3'b100, 13'h0601, 2'b01, 16'hA500, 1'b1});
            end
         end
         adv();
      end
   endtask

   task automatic test_read();
      do_reset();
      req = 4'b0010; we = '0; addr = '0; addr[AD +: AD] = 23'h000C02; sd_data_in = 16'h5A3C;
      repeat (2 * F) begin
         if (t == F) req = '0;
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL read_model t=%0d got=%h exp=%h", t, got_v, exp_v); end
         if (t == F + NB + 1) begin
            checks++;
            if ({sd_cmd, sd_a, sd_ba, sd_dqm} !== {3'b101, 13'h0601, 2'd1, 2'b10}) begin
               errors++; $display("FAIL read_cmd got=%h exp=%h", {sd_cmd, sd_a, sd_ba, sd_dqm}, {3'b101, 13'h0601, 2'd1, 2'b10});
            end
         end
         if (t == F + NB + 1 + CL) begin
            checks++;
            if (rvalid !== 4'b0000) begin errors++; $display("FAIL read_early_rvalid got=%b exp=0000", rvalid); end
         end
         if (t == F + NB + 1 + CL + 1) begin
            checks++;
            if ({rvalid, rdata[15:8]} !== {4'b0010, 8'h3C}) begin
               errors++; $display("FAIL read_rvalid got=%h exp=%h", {rvalid, rdata[15:8]}, {4'b0010, 8'h3C});
            end
         end
         adv();
      end
   endtask

   task automatic test_concurrent();
      do_reset();
      req = 4'hF; we = '0; rand_addr();
      repeat (2 * F) begin
         if (t == F) req = '0;
         sd_data_in = 16'($urandom);
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL conc_model t=%0d got=%h exp=%h", t, got_v, exp_v); end
         if (t >= F && t < F + NB) begin
            checks++;
            if ({sd_cmd, sd_ba} !== {3'b011, 2'(t - F)}) begin
               errors++; $display("FAIL conc_act t=%0d got=%h exp=%h", t, {sd_cmd, sd_ba}, {3'b011, 2'(t - F)});
            end
         end
         if (t >= F + NB && t < F + 2 * NB) begin
            checks++;
            if ({sd_cmd, sd_ba} !== {3'b101, 2'(t - F - NB)}) begin
               errors++; $display("FAIL conc_read t=%0d got=%h exp=%h", t, {sd_cmd, sd_ba}, {3'b101, 2'(t - F - NB)});
            end
         end
         if (t >= F + NB + CL + 1 && t < F + 2 * NB + CL + 1) begin
            checks++;
            if (rvalid !== 4'(1 << (t - F - NB - CL - 1))) begin
               errors++; $display("FAIL conc_rvalid t=%0d got=%b exp=%b", t, rvalid, 4'(1 << (t - F - NB - CL - 1)));
            end
         end
         adv();
      end
   endtask

   task automatic test_refresh();
      do_reset();
      req = 4'hF; en = 1'b1;
      repeat (10 * F) begin
         we = NB'($urandom); rand_addr(); wdata = 32'($urandom); sd_data_in = 16'($urandom);
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL refresh_model t=%0d got=%h exp=%h", t, got_v, exp_v); end
         if (t == 3 * F - 1 || t == 5 * F - 1) begin
            checks++;
            if (ack !== 4'hF) begin errors++; $display("FAIL refresh_ack_on t=%0d got=%b exp=1111", t, ack); end
         end
         if (t == 4 * F - 1 || t == 8 * F - 1) begin
            checks++;
            if (ack !== 4'h0) begin errors++; $display("FAIL refresh_ack_off t=%0d got=%b exp=0000", t, ack); end
         end
         if (t == 4 * F || t == 8 * F) begin
            checks++;
            if ({refresh_active, sd_cmd} !== {1'b1, 3'b001}) begin
               errors++; $display("FAIL refresh_cmd t=%0d got=%h exp=%h", t, {refresh_active, sd_cmd}, {1'b1, 3'b001});
            end
         end
         if (t == 4 * F + 1) begin
            checks++;
            if ({refresh_active, sd_cmd} !== {1'b1, 3'b111}) begin
               errors++; $display("FAIL refresh_nop got=%h exp=%h", {refresh_active, sd_cmd}, {1'b1, 3'b111});
            end
         end
         adv();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0001; we = '0; rand_addr(); sd_data_in = 16'($urandom);
      while (t < F + NB) begin
         if (t == F) req = '0;
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL midrst_pre t=%0d got=%h exp=%h", t, got_v, exp_v); end
         adv();
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      req = 4'b0001;
      repeat (2 * F) begin
         if (t == F) req = '0;
         sd_data_in = 16'($urandom);
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL midrst_model t=%0d got=%h exp=%h", t, got_v, exp_v); end
         if (t < F) begin
            checks++;
            if ({rvalid, sd_cmd, sd_dqm, sd_data_out_en} !== {4'h0, 3'b111, 2'b11, 1'b0}) begin
               errors++; $display("FAIL midrst_idle t=%0d got=%h exp=%h", t, {rvalid, sd_cmd, sd_dqm, sd_data_out_en}, {4'h0, 3'b111, 2'b11, 1'b0});
            end
         end
         if (t == F - 1) begin
            checks++;
            if (ack !== 4'b0001) begin errors++; $display("FAIL midrst_ack got=%b exp=0001", ack); end
         end
         adv();
      end
   endtask

   task automatic test_random();
      do_reset();
      repeat (40 * F) begin
         req = NB'($urandom); we = NB'($urandom); en = ($urandom % 4) != 0;
         rand_addr(); wdata = 32'($urandom); sd_data_in = 16'($urandom);
         eval();
         checks++;
         if (got_v !== exp_v) begin errors++; $display("FAIL random t=%0d got=%h exp=%h", t, got_v, exp_v); end
         adv();
      end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; en = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; sd_data_in = '0;
      model_reset();
      test_reset();
      test_write();
      test_read();
      test_concurrent();
      test_refresh();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sdram_multibank_scheduler.md
# sdram_multibank_scheduler

Time-sliced SDRAM command scheduler for 2 or 4 interleaved banks with an internal frame counter. Each bank runs an 8-bit port with a req/ack handshake and an activate / read-or-write-with-auto-precharge / capture sequence. It adds configurable CAS latency and periodic auto-refresh. It sits between the per-bank client logic and the SDRAM pad/PHY layer, after SDRAM init has completed.

## Interface
- NUM_BANKS, 2: interleaved banks, 2 or 4; frame length F = 4*NUM_BANKS cycles.
- ADDR_DEPTH, 23: per-port byte address width; ROW_DEPTH = ADDR_DEPTH-COL_DEPTH-1 (at most 13).
- COL_DEPTH, 10: column address width.
- CAS_LATENCY, 2: 2 or 3 cycles.
- REFRESH_INTERVAL, 64: frames per refresh period (at least 2); one frame in each period is a refresh frame.
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- en  in  1  enables request acceptance.
- req  in  NUM_BANKS  per-bank request.
- we  in  NUM_BANKS  1 = write, 0 = read.
- addr  in  NUM_BANKS*ADDR_DEPTH  per-bank byte address; bank b uses slice b.
- wdata  in  NUM_BANKS*8  per-bank write byte.
- ack  out  NUM_BANKS  one-cycle pulse: request accepted.
- rdata  out  NUM_BANKS*8  per-bank read byte.
- rvalid  out  NUM_BANKS  one-cycle pulse: rdata[b] updated.
- refresh_active  out  1  high for the whole refresh frame.
- sd_data_in  in  16  SDRAM DQ in.
- sd_data_out  out  16  SDRAM DQ out.
- sd_data_out_en  out  1  DQ output enable.
- sd_a  out  13  SDRAM address.
- sd_ba  out  2  bank address; bit 1 is 0 when NUM_BANKS=2.
- sd_cmd  out  3  {RAS,CAS,WE}: ACTIVATE 011, READ 101, WRITE 100, REFRESH 001, NOP 111.
- sd_dqm  out  2  byte masks, active-high mask.

## Operation
- Frame counter fc counts 0..F-1 and wraps. Slot owner is b = fc mod NUM_BANKS; phase p = fc / NUM_BANKS.
- **Acceptance** at fc = F-1: for each bank with req & en, and not entering a refresh frame:
  - latch we, addr and wdata;
  - pulse ack[b];
  - mark the bank busy for the next frame.
- **Address decode:** {row, col} = addr[ADDR_DEPTH-1:1]; ul = addr[0].
- **Busy bank b in a normal frame:**
  - p=0, fc=b: ACTIVATE, sd_a = row (zero-extended), sd_ba = b.
  - p=1, fc=NUM_BANKS+b:
    - command is READ or WRITE; sd_a = col (zero-extended) with sd_a[10]=1; sd_ba = b; sd_dqm = {~ul, ul}.
    - on WRITE: sd_data_out_en=1; the selected byte lane carries wdata and the other lane is 0.
  - READ capture at fc = NUM_BANKS+b+CAS_LATENCY:
    - take sd_data_in[15:8] if ul, else [7:0];
    - rdata[b] updates on the next edge and rvalid[b] pulses that same cycle.
- **All other cycles:** sd_cmd NOP, sd_a 0, sd_ba 0, sd_dqm 11, sd_data_out_en 0.
- **Refresh:**
  - Frame counter rc increments at each fc = F-1.
  - When rc = REFRESH_INTERVAL-1 at fc = F-1, no acks are given and rc is cleared. The next frame is the refresh frame.
  - In the refresh frame, refresh_active=1, fc=0 issues REFRESH, and every other cycle is NOP.
- **en low:** no new acceptances. A frame already in flight completes, including capture and rvalid. Counters keep running.
- **Reset:**
  - fc=0, rc=0, all busy flags cleared.
  - rdata 0, ack 0, rvalid 0, refresh_active 0; SDRAM outputs idle as above.
  - Reset mid-frame abandons the in-flight access with no rvalid.
  - The first frame after reset is always idle.

## Timing
- Request to ack: at most F cycles; ack coincides with fc = F-1. Hold req until ack. Holding req after ack requests another access in the next frame.
- ACTIVATE to READ/WRITE: NUM_BANKS cycles.
- Read ack to rvalid: NUM_BANKS + b + CAS_LATENCY + 2 cycles.
- Slots never collide: each cycle carries at most one command.
- A capture always falls inside its own frame: max NUM_BANKS*2 + 2 < F.
- Read and write are the same length; there is no turnaround penalty.
- Refresh costs one frame per REFRESH_INTERVAL frames.

## Test plan
- **Reset idle.** NUM_BANKS=2, CL=2. Hold rst 3 cycles, then run 2 frames with req=0 -> sd_cmd=111, sd_dqm=11, ack=0, rvalid=0 throughout.
- **Bank0 write.** Write addr 0x000C03, wdata 0xA5 -> ack at fc=7. Next frame:
  - fc0: ACTIVATE, sd_a=0x0001, sd_ba=0;
  - fc2: WRITE, sd_a=0x0601, sd_dqm=01, sd_data_out=0xA500, sd_data_out_en=1.
- **Bank1 read, CL=2 and CL=3.** Read addr 0x000C02 with SDRAM model returning 0x5A3C -> READ at fc3. rdata[1]=0x3C and rvalid[1] pulses at fc6 (CL2) or fc7 (CL3).
- **Concurrent banks, NUM_BANKS=4.** Four simultaneous reads -> ACTIVATE at fc0..3 and READ at fc4..7 with sd_ba 0..3. Four rvalid pulses, in bank order, each carrying the correct byte.
- **Refresh.** REFRESH_INTERVAL=4, req held high continuously -> every 4th frame:
  - no ack at the preceding fc=F-1;
  - refresh_active=1 and REFRESH at fc0;
  - acks resume the frame after.
- **Reset mid-read.** Assert rst at fc4 of a bank0 read frame -> no rvalid, outputs idle next cycle, and a fresh request is accepted at the first fc=F-1.
